// File: rtl/sb_pkg.sv
// Shared constants and helpers for the register scoreboard: default sizes,
// per-register pending-counter operation encoding, and source-field extraction.
package sb_pkg;

  localparam int NREG_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int NRD_DEF   = 2;
  localparam int CNT_W_DEF = 2;

  // Upper bounds for the width-agnostic source-field helper.
  localparam int MAX_AW  = 8;
  localparam int MAX_BUS = 64;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

  // Flush wins over everything; a simultaneous issue and retire cancel out.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec,
                                     input logic clr, input logic nonzero);
    cnt_op_e op;
    op = CNT_HOLD;
    if (clr)                 op = CNT_CLR;
    else if (inc && dec)     op = CNT_HOLD;
    else if (inc)            op = CNT_INC;
    else if (dec && nonzero) op = CNT_DEC;
    return op;
  endfunction

  function automatic logic [MAX_AW-1:0] src_field(input logic [MAX_BUS-1:0] bus,
                                                  input int idx, input int aw);
    logic [MAX_AW-1:0] mask;
    mask = (MAX_AW'(1) << aw) - MAX_AW'(1);
    return MAX_AW'(bus >> (idx * aw)) & mask;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register: counts outstanding
// long producers, saturates at all-ones and flags a retire with nothing pending.
module sb_counter
  import sb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             busy_o,
  output logic             sat_o,
  output logic             uflow_o
);

  localparam logic [CNT_W-1:0] MAXC = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  cnt_op_e          op;

  always_comb begin
    cnt_d = cnt_q;
    op    = cnt_op(inc_i, dec_i, clr_i, cnt_q != '0);
    unique case (op)
      CNT_CLR: cnt_d = '0;
      CNT_INC: if (cnt_q != MAXC) cnt_d = cnt_q + CNT_W'(1);
      CNT_DEC: cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_nxt_o = cnt_d;
  assign busy_o    = cnt_q != '0;
  assign sat_o     = cnt_q == MAXC;
  assign uflow_o   = dec_i & ~inc_i & ~clr_i & (cnt_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: stalls issue on RAW hazards against
// non-forwardable outstanding writes and on pending-counter saturation.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int AW    = AW_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [NRD*AW-1:0]   issue_rsrc,
  input  logic [NRD-1:0]      issue_ruse,
  input  logic                issue_long,
  input  logic [AW-1:0]       issue_dest,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_dest,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec,
  output logic [AW+CNT_W-1:0] pend_total,
  output logic                err_underflow
);

  localparam int PW = AW + CNT_W;

  logic [CNT_W-1:0]   cnt_nxt [NREG];
  logic [NREG-1:0]    busy_w, sat_w, uflow_w;
  logic [2**AW-1:0]   busy_ext, sat_ext;
  logic [AW-1:0]      src_w [NRD];
  logic [MAX_BUS-1:0] rsrc_pad;
  logic               raw_hz, waw_hz, issue_fire;
  logic [PW-1:0]      pend_d, pend_q;
  logic               err_d, err_q;

  // Register 0 is hardwired zero and never tracked.
  assign busy_w[0]  = 1'b0;
  assign sat_w[0]   = 1'b0;
  assign uflow_w[0] = 1'b0;
  assign cnt_nxt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .resetn    (resetn),
      .inc_i     (issue_fire && (issue_dest == AW'(r))),
      .dec_i     (wb_valid && (wb_dest == AW'(r))),
      .clr_i     (flush),
      .cnt_nxt_o (cnt_nxt[r]),
      .busy_o    (busy_w[r]),
      .sat_o     (sat_w[r]),
      .uflow_o   (uflow_w[r])
    );
  end

  assign rsrc_pad = MAX_BUS'(issue_rsrc);

  for (genvar i = 0; i < NRD; i++) begin : g_src
    assign src_w[i] = AW'(src_field(rsrc_pad, i, AW));
  end

  // Hazards look only at registered counts, so a same-cycle retire gives no credit.
  always_comb begin
    busy_ext           = '0;
    sat_ext            = '0;
    busy_ext[NREG-1:0] = busy_w;
    sat_ext[NREG-1:0]  = sat_w;
    raw_hz             = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (issue_ruse[i] && (src_w[i] != '0) && busy_ext[src_w[i]]) raw_hz = 1'b1;
    end
    waw_hz = issue_long && (issue_dest != '0) && sat_ext[issue_dest];
  end

  assign issue_ready = ~(raw_hz | waw_hz);
  assign issue_fire  = issue_valid & issue_ready & issue_long & ~flush;

  always_comb begin
    pend_d = '0;
    for (int r = 0; r < NREG; r++) pend_d = pend_d + PW'(cnt_nxt[r]);
    err_d = err_q | (|uflow_w);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec      = busy_w;
  assign pend_total    = pend_q;
  assign err_underflow = err_q;

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register scoreboard for the decode stage.
- Tracks register writes that are still outstanding and cannot be forwarded: loads in flight, and mult/div results that take many cycles.
- Stalls issue on RAW (read-after-write) hazards against those writes, and on counter saturation for WAW (write-after-write).
- Replaces the fixed single-load-in-EXE stall check. Supports several read ports, multiple outstanding writes per register, and a pipeline flush.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register address width; must satisfy 2^AW >= NREG.
- NRD, 2, number of source read ports checked per issued instruction.
- CNT_W, 2, width of each per-register pending counter; MAXC = 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_ready  out  1  no hazard; instruction may issue this cycle.
- issue_rsrc  in  NRD*AW  source register addresses; port i occupies bits [i*AW +: AW].
- issue_ruse  in  NRD  per-port flag: source i is actually read.
- issue_long  in  1  instruction produces a non-forwardable result.
- issue_dest  in  AW  destination register of the long producer.
- wb_valid  in  1  a long producer completes this cycle; its result is forwardable from the next cycle.
- wb_dest  in  AW  destination register of the completing producer.
- flush  in  1  pipeline flush (exception/eret); discards all outstanding producers.
- busy_vec  out  NREG  bit r = pending count of register r is nonzero.
- pend_total  out  AW+CNT_W  total outstanding long writes.
- err_underflow  out  1  sticky: wb_valid arrived for a register whose count is 0.

Behaviour:
- Reset (asynchronous, resetn=0): all counters 0; busy_vec=0; pend_total=0; err_underflow=0. issue_ready=1 follows from the zero counters.
- Register 0 is never tracked. Issue with dest 0 and wb with dest 0 cause no counter change and raise no error.
- RAW hazard: exists when, for any port i, issue_ruse[i]=1, src_i≠0 and cnt[src_i]≠0.
- WAW saturation: exists when issue_long=1, issue_dest≠0 and cnt[issue_dest]==MAXC.
- issue_ready = !(RAW | WAW saturation).
  - Combinational from registered counters only.
  - No same-cycle credit from wb_valid: a register retiring this cycle still stalls; ready rises the next cycle.
  - issue_ready does not depend on issue_valid.
- issue_fire = issue_valid & issue_ready & issue_long & !flush.
- Counter update per register r (next cycle):
  - flush=1: cnt=0, overriding any same-cycle issue or wb.
  - fire and wb to the same r: cnt unchanged.
  - fire only: cnt+1; cannot exceed MAXC because the WAW stall prevents it.
  - wb only with cnt>0: cnt-1.
  - wb only with cnt==0: cnt unchanged and err_underflow set to 1.
- err_underflow clears only on reset; flush does not clear it.
- pend_total is registered: the sum of all counters, updated in the same cycle as the counters.
- busy_vec is registered, equal to the OR-reduction of each counter.
- Reset asserted mid-operation: all state cleared immediately; any wb arriving afterwards for lost entries sets err_underflow, which is expected and ignored by the bench after reset.

Decomposition:
- Package sb_pkg holds:
  - default parameter constants;
  - a function for the pending-counter next-state encoding;
  - a helper that extracts field i from issue_rsrc.
- Sub-module sb_counter: one CNT_W saturating up/down counter with inc, dec, clr inputs and busy and underflow outputs. Instantiated NREG-1 times in a generate loop.
- The top level holds the hazard reduction, the pend_total adder tree and the sticky error flag.

Test Plan:
- Load-use stall: issue long dest=5; next cycle src0=5 ruse=1 gives issue_ready=0. Assert wb dest=5; ready stays 0 that cycle, is 1 the following cycle, busy_vec[5]=0.
- Register zero: issue long dest=0, then src0=0 and src1=0 → issue_ready=1 throughout; busy_vec=0; pend_total=0.
- Saturation (CNT_W=2): three long issues to dest=7 → cnt=3 and pend_total=3. Fourth issue to dest=7 gives issue_ready=0; after one wb to 7 it is accepted.
- Same-cycle issue and wb: cnt[9]=1; fire long dest=9 together with wb dest=9 → cnt stays 1 and busy_vec[9]=1. One further wb → busy_vec[9]=0.
- Flush priority: cnt[3]=2, cnt[4]=1; flush asserted together with an issue to 6 and a wb to 3 → all counters 0 next cycle, pend_total=0, err_underflow=0.
- Underflow and reset: wb dest=12 with cnt 0 → err_underflow=1 and stays 1 across flush. Drop resetn mid-cycle → err_underflow=0 and busy_vec=0 asynchronously.
